// File: rtl/argon_pkg.sv
// Shared types and encodings for the Argon memory port arbiter.
package argon_pkg;

    localparam logic [2:0] RDMASK_NONE = 3'd0;
    localparam logic [2:0] RDMASK_B    = 3'd1;
    localparam logic [2:0] RDMASK_H    = 3'd2;
    localparam logic [2:0] RDMASK_W    = 3'd3;
    localparam logic [2:0] RDMASK_BU   = 3'd4;
    localparam logic [2:0] RDMASK_HU   = 3'd5;

    localparam logic [1:0] WRMASK_NONE = 2'd0;
    localparam logic [1:0] WRMASK_B    = 2'd1;
    localparam logic [1:0] WRMASK_H    = 2'd2;
    localparam logic [1:0] WRMASK_W    = 2'd3;

    typedef enum logic {
        ARB_IDLE,
        ARB_ACCESS
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [2:0]  rd_mask;
        logic [1:0]  wr_mask;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '{
        addr:    32'd0,
        wr_data: 32'd0,
        rd_mask: RDMASK_NONE,
        wr_mask: WRMASK_NONE
    };

endpackage

// File: rtl/argon_mem_arbiter_if.sv
// One requester port of the memory arbiter: request fields in, gnt/done/rd_data back.
interface argon_mem_arbiter_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_mask;
    logic [1:0]  wr_mask;
    logic        gnt;
    logic        done;
    logic [31:0] rd_data;

    modport master (
        output req, addr, wr_data, rd_mask, wr_mask,
        input  gnt, done, rd_data
    );

    modport slave (
        input  req, addr, wr_data, rd_mask, wr_mask,
        output gnt, done, rd_data
    );

endinterface

// File: rtl/argon_rr_pick2.sv
// Combinational two-way picker: fixed priority to port 0, or round-robin away from i_last.
module argon_rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_fixed_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = (i_fixed_prio || i_last) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/argon_mem_arbiter.sv
// Arbitrates the single Argon memory port between the CPU (port 0) and DMA/debug (port 1),
// holding the winning single-beat access on the bus for MEM_LATENCY cycles.
module argon_mem_arbiter
    import argon_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter bit          CPU_PRIORITY = 1'b0
) (
    input  logic                  sys_clk,
    input  logic                  i_reset,
    argon_mem_arbiter_if.slave    m0,
    argon_mem_arbiter_if.slave    m1,
    output logic [31:0]           o_mem_addr,
    output logic [31:0]           o_mem_wr_data,
    output logic [2:0]            o_mem_rd_mask,
    output logic [1:0]            o_mem_wr_mask,
    input  logic [31:0]           i_mem_rd_data
);

    localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            r_last_q, r_last_d;
    mem_req_t        mreq_q, mreq_d;
    logic [1:0]      done_q, done_d;
    logic [31:0]     rd_data0_q, rd_data0_d;
    logic [31:0]     rd_data1_q, rd_data1_d;

    logic [1:0]      pick;
    logic [1:0]      grant;
    logic            gnt_port;
    mem_req_t        new_req;
    logic [31:0]     rd_val;

    argon_rr_pick2 u_pick (
        .i_req        ({m1.req, m0.req}),
        .i_last       (r_last_q),
        .i_fixed_prio (CPU_PRIORITY),
        .o_grant      (pick)
    );

    assign grant    = (state_q == ARB_IDLE) ? pick : 2'b00;
    assign gnt_port = grant[1];

    // A write wins over a simultaneous read: the read mask is dropped at latch time.
    always_comb begin
        new_req.addr    = gnt_port ? m1.addr    : m0.addr;
        new_req.wr_data = gnt_port ? m1.wr_data : m0.wr_data;
        new_req.wr_mask = gnt_port ? m1.wr_mask : m0.wr_mask;
        new_req.rd_mask = gnt_port ? m1.rd_mask : m0.rd_mask;
        if (new_req.wr_mask != WRMASK_NONE) begin
            new_req.rd_mask = RDMASK_NONE;
        end
    end

    assign rd_val = (mreq_q.rd_mask != RDMASK_NONE) ? i_mem_rd_data : 32'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        r_last_d   = r_last_q;
        mreq_d     = mreq_q;
        done_d     = 2'b00;
        rd_data0_d = 32'd0;
        rd_data1_d = 32'd0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|grant) begin
                    state_d  = ARB_ACCESS;
                    cnt_d    = CntInit;
                    owner_d  = gnt_port;
                    r_last_d = gnt_port;
                    mreq_d   = new_req;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d         = ARB_IDLE;
                    mreq_d          = MEM_REQ_IDLE;
                    done_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rd_data1_d = rd_val;
                    end else begin
                        rd_data0_d = rd_val;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            r_last_q   <= 1'b1;
            mreq_q     <= MEM_REQ_IDLE;
            done_q     <= 2'b00;
            rd_data0_q <= 32'd0;
            rd_data1_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            r_last_q   <= r_last_d;
            mreq_q     <= mreq_d;
            done_q     <= done_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
        end
    end

    assign m0.gnt     = grant[0];
    assign m1.gnt     = grant[1];
    assign m0.done    = done_q[0];
    assign m1.done    = done_q[1];
    assign m0.rd_data = rd_data0_q;
    assign m1.rd_data = rd_data1_q;

    assign o_mem_addr    = mreq_q.addr;
    assign o_mem_wr_data = mreq_q.wr_data;
    assign o_mem_rd_mask = mreq_q.rd_mask;
    assign o_mem_wr_mask = mreq_q.wr_mask;

endmodule

// File: tb/tb_argon_mem_arbiter.sv
// Directed bench: round-robin instance (u_rr) and CPU-priority instance (u_fp), MEM_LATENCY=2.
module tb_argon_mem_arbiter;
    import argon_pkg::*;

    logic sys_clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 sys_clk = ~sys_clk;

    argon_mem_arbiter_if m0_rr ();
    argon_mem_arbiter_if m1_rr ();
    argon_mem_arbiter_if m0_fp ();
    argon_mem_arbiter_if m1_fp ();

    logic [31:0] mem_addr_rr, mem_wr_data_rr, mem_rd_data_rr;
    logic [2:0]  mem_rd_mask_rr;
    logic [1:0]  mem_wr_mask_rr;
    logic [31:0] mem_addr_fp, mem_wr_data_fp, mem_rd_data_fp;
    logic [2:0]  mem_rd_mask_fp;
    logic [1:0]  mem_wr_mask_fp;

    argon_mem_arbiter #(.MEM_LATENCY(2), .CPU_PRIORITY(1'b0)) u_rr (
        .sys_clk       (sys_clk),
        .i_reset       (i_reset),
        .m0            (m0_rr),
        .m1            (m1_rr),
        .o_mem_addr    (mem_addr_rr),
        .o_mem_wr_data (mem_wr_data_rr),
        .o_mem_rd_mask (mem_rd_mask_rr),
        .o_mem_wr_mask (mem_wr_mask_rr),
        .i_mem_rd_data (mem_rd_data_rr)
    );

    argon_mem_arbiter #(.MEM_LATENCY(2), .CPU_PRIORITY(1'b1)) u_fp (
        .sys_clk       (sys_clk),
        .i_reset       (i_reset),
        .m0            (m0_fp),
        .m1            (m1_fp),
        .o_mem_addr    (mem_addr_fp),
        .o_mem_wr_data (mem_wr_data_fp),
        .o_mem_rd_mask (mem_rd_mask_fp),
        .o_mem_wr_mask (mem_wr_mask_fp),
        .i_mem_rd_data (mem_rd_data_fp)
    );

    int checks   = 0;
    int failures = 0;

    logic [1:0] rr_exp_gnt  [0:12];
    logic [1:0] rr_exp_done [0:12];
    logic [1:0] prev_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        m0_rr.req = 0; m0_rr.addr = 0; m0_rr.wr_data = 0;
        m0_rr.rd_mask = RDMASK_NONE; m0_rr.wr_mask = WRMASK_NONE;
        m1_rr.req = 0; m1_rr.addr = 0; m1_rr.wr_data = 0;
        m1_rr.rd_mask = RDMASK_NONE; m1_rr.wr_mask = WRMASK_NONE;
        m0_fp.req = 0; m0_fp.addr = 0; m0_fp.wr_data = 0;
        m0_fp.rd_mask = RDMASK_NONE; m0_fp.wr_mask = WRMASK_NONE;
        m1_fp.req = 0; m1_fp.addr = 0; m1_fp.wr_data = 0;
        m1_fp.rd_mask = RDMASK_NONE; m1_fp.wr_mask = WRMASK_NONE;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        clear_reqs();
        @(negedge sys_clk);
        @(negedge sys_clk);
        i_reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rr_exp_gnt  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01,
                        2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        rr_exp_done = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                        2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        mem_rd_data_rr = 32'd0;
        mem_rd_data_fp = 32'd0;
        clear_reqs();

        // Reset values
        @(negedge sys_clk); #1;
        check_eq("rst_addr", mem_addr_rr, 32'd0);
        check_eq("rst_wr_data", mem_wr_data_rr, 32'd0);
        check_eq("rst_rd_mask", {29'd0, mem_rd_mask_rr}, {29'd0, RDMASK_NONE});
        check_eq("rst_wr_mask", {30'd0, mem_wr_mask_rr}, {30'd0, WRMASK_NONE});
        check_eq("rst_done", {30'd0, m1_rr.done, m0_rr.done}, 32'd0);
        check_eq("rst_rd_data0", m0_rr.rd_data, 32'd0);
        check_eq("rst_rd_data1", m1_rr.rd_data, 32'd0);
        @(negedge sys_clk);
        i_reset = 1'b0;

        // m0 read of 0x100
        @(negedge sys_clk);
        m0_rr.req = 1; m0_rr.addr = 32'h100; m0_rr.rd_mask = RDMASK_W; #1;
        check_eq("rd_gnt0_c0", m0_rr.gnt, 1);
        check_eq("rd_addr_c0", mem_addr_rr, 32'd0);
        @(negedge sys_clk);
        m0_rr.req = 0; mem_rd_data_rr = 32'hDEADBEEF; #1;
        check_eq("rd_addr_c1", mem_addr_rr, 32'h100);
        check_eq("rd_mask_c1", {29'd0, mem_rd_mask_rr}, {29'd0, RDMASK_W});
        check_eq("rd_gnt0_c1", m0_rr.gnt, 0);
        @(negedge sys_clk); #1;
        check_eq("rd_addr_c2", mem_addr_rr, 32'h100);
        check_eq("rd_done0_c2", m0_rr.done, 0);
        @(negedge sys_clk); #1;
        check_eq("rd_done0_c3", m0_rr.done, 1);
        check_eq("rd_data0_c3", m0_rr.rd_data, 32'hDEADBEEF);
        check_eq("rd_done1_c3", m1_rr.done, 0);
        check_eq("rd_addr_c3", mem_addr_rr, 32'd0);
        check_eq("rd_mask_c3", {29'd0, mem_rd_mask_rr}, {29'd0, RDMASK_NONE});
        @(negedge sys_clk); #1;
        check_eq("rd_done0_c4", m0_rr.done, 0);
        check_eq("rd_data0_c4", m0_rr.rd_data, 32'd0);

        // Round-robin back-to-back, both ports requesting from the first cycle after reset
        do_reset();
        prev_gnt = 2'b00;
        for (int c = 0; c <= 12; c++) begin
            @(negedge sys_clk);
            if (c == 0) begin
                m0_rr.req = 1; m0_rr.addr = 32'h10;
                m1_rr.req = 1; m1_rr.addr = 32'h20;
            end
            if (prev_gnt[0]) m0_rr.req = 0;
            if (prev_gnt[1]) m1_rr.req = 0;
            if (m0_rr.done) m0_rr.req = 1;
            if (m1_rr.done) m1_rr.req = 1;
            #1;
            check_eq($sformatf("rr_gnt_c%0d", c), {30'd0, m1_rr.gnt, m0_rr.gnt},
                     {30'd0, rr_exp_gnt[c]});
            check_eq($sformatf("rr_done_c%0d", c), {30'd0, m1_rr.done, m0_rr.done},
                     {30'd0, rr_exp_done[c]});
            prev_gnt = {m1_rr.gnt, m0_rr.gnt};
        end
        @(negedge sys_clk);
        clear_reqs();
        drain(4);

        // CPU priority: m1 waits while m0 keeps requesting
        for (int c = 0; c <= 8; c++) begin
            @(negedge sys_clk);
            if (c == 0) begin
                m0_fp.req = 1; m0_fp.addr = 32'h30;
                m1_fp.req = 1; m1_fp.addr = 32'h40;
            end
            #1;
            check_eq($sformatf("fp_gnt_c%0d", c), {30'd0, m1_fp.gnt, m0_fp.gnt},
                     (c % 3 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge sys_clk);
        m0_fp.req = 0; #1;
        check_eq("fp_gnt_m0_dropped", {30'd0, m1_fp.gnt, m0_fp.gnt}, 32'd2);
        @(negedge sys_clk);
        clear_reqs();
        drain(4);

        // m1 write of 0x12345678 to 0x200
        @(negedge sys_clk);
        m1_rr.req = 1; m1_rr.addr = 32'h200; m1_rr.wr_data = 32'h12345678;
        m1_rr.wr_mask = WRMASK_W; #1;
        check_eq("wr_gnt1_c0", m1_rr.gnt, 1);
        @(negedge sys_clk);
        m1_rr.req = 0; mem_rd_data_rr = 32'hCAFEF00D; #1;
        check_eq("wr_addr_c1", mem_addr_rr, 32'h200);
        check_eq("wr_data_c1", mem_wr_data_rr, 32'h12345678);
        check_eq("wr_wmask_c1", {30'd0, mem_wr_mask_rr}, {30'd0, WRMASK_W});
        check_eq("wr_rmask_c1", {29'd0, mem_rd_mask_rr}, {29'd0, RDMASK_NONE});
        @(negedge sys_clk); #1;
        check_eq("wr_data_c2", mem_wr_data_rr, 32'h12345678);
        check_eq("wr_wmask_c2", {30'd0, mem_wr_mask_rr}, {30'd0, WRMASK_W});
        @(negedge sys_clk); #1;
        check_eq("wr_done_c3", {30'd0, m1_rr.done, m0_rr.done}, 32'd2);
        check_eq("wr_rd_data1_c3", m1_rr.rd_data, 32'd0);
        check_eq("wr_wmask_c3", {30'd0, mem_wr_mask_rr}, {30'd0, WRMASK_NONE});
        drain(1);

        // m0 with both masks set: treated as a write
        @(negedge sys_clk);
        m0_rr.req = 1; m0_rr.addr = 32'h280; m0_rr.wr_data = 32'hA5A5A5A5;
        m0_rr.rd_mask = RDMASK_W; m0_rr.wr_mask = WRMASK_H; #1;
        check_eq("both_gnt0_c0", m0_rr.gnt, 1);
        @(negedge sys_clk);
        clear_reqs(); #1;
        check_eq("both_wmask_c1", {30'd0, mem_wr_mask_rr}, {30'd0, WRMASK_H});
        check_eq("both_rmask_c1", {29'd0, mem_rd_mask_rr}, {29'd0, RDMASK_NONE});
        drain(1);
        @(negedge sys_clk); #1;
        check_eq("both_done0_c3", m0_rr.done, 1);
        check_eq("both_rd_data0_c3", m0_rr.rd_data, 32'd0);
        drain(1);

        // Null access: both masks NONE
        @(negedge sys_clk);
        m0_rr.req = 1; m0_rr.addr = 32'h300; #1;
        check_eq("null_gnt0_c0", m0_rr.gnt, 1);
        @(negedge sys_clk);
        clear_reqs(); #1;
        check_eq("null_addr_c1", mem_addr_rr, 32'h300);
        @(negedge sys_clk); #1;
        check_eq("null_done0_c2", m0_rr.done, 0);
        @(negedge sys_clk); #1;
        check_eq("null_done0_c3", m0_rr.done, 1);
        check_eq("null_rd_data0_c3", m0_rr.rd_data, 32'd0);
        drain(1);

        // Reset in cycle 1 of an access
        @(negedge sys_clk);
        m0_rr.req = 1; m0_rr.addr = 32'h400; m0_rr.rd_mask = RDMASK_W;
        mem_rd_data_rr = 32'h55AA55AA; #1;
        check_eq("abort_gnt0_c0", m0_rr.gnt, 1);
        @(negedge sys_clk);
        clear_reqs();
        i_reset = 1'b1; #1;
        check_eq("abort_addr", mem_addr_rr, 32'd0);
        check_eq("abort_rmask", {29'd0, mem_rd_mask_rr}, {29'd0, RDMASK_NONE});
        check_eq("abort_wmask", {30'd0, mem_wr_mask_rr}, {30'd0, WRMASK_NONE});
        check_eq("abort_done", {30'd0, m1_rr.done, m0_rr.done}, 32'd0);
        @(negedge sys_clk);
        i_reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge sys_clk); #1;
            check_eq($sformatf("abort_no_done_%0d", c), {30'd0, m1_rr.done, m0_rr.done}, 32'd0);
        end
        @(negedge sys_clk);
        m0_rr.req = 1; m1_rr.req = 1; #1;
        check_eq("abort_tie_gnt", {30'd0, m1_rr.gnt, m0_rr.gnt}, 32'd1);
        @(negedge sys_clk);
        clear_reqs();
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
